// File: rtl/replay_phase_sequencer.sv
// Run controller: steps one task through its replay iterations, one edge phase then one vertex phase each.
// Every output is decoded from registered state, so no input reaches an output combinationally.
module replay_phase_sequencer #(
  parameter int NUM_EDGE_PE = 4,
  parameter int ITER_W      = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ITER_W-1:0]      num_iter,
  input  logic                   dispatch_empty,
  input  logic [NUM_EDGE_PE-1:0] pe_idle,
  input  logic                   edge_buffer_busy,
  input  logic                   rs_empty,
  input  logic                   vertex_done,
  output logic                   dispatch_en,
  output logic                   vertex_en,
  output logic [ITER_W-1:0]      cur_replay_iter,
  output logic                   iter_advance,
  output logic                   task_complete,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [2:0]             phase
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_DISPATCH     = 3'd1,
    S_EDGE_DRAIN   = 3'd2,
    S_VERTEX       = 3'd3,
    S_VERTEX_DRAIN = 3'd4,
    S_NEXT_ITER    = 3'd5,
    S_DONE         = 3'd6
  } state_t;

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0]    TMO_HIT     = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE     = TMO_W'(1);
  localparam logic [ITER_W-1:0]   ITER_ONE    = ITER_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [SETTLE_W-1:0] r_settle;
  logic [TMO_W-1:0]    r_tmo;
  logic [ITER_W-1:0]   r_num_iter;
  logic [ITER_W-1:0]   r_cur_iter;
  logic                r_iter_advance;
  logic                r_timeout_err;

  logic w_edge_quiet;
  logic w_vertex_quiet;
  logic w_in_drain;
  logic w_quiet;
  logic w_settled;
  logic w_start_ok;
  logic w_last_iter;
  logic w_state_change;

  assign w_edge_quiet   = (&pe_idle) & ~edge_buffer_busy;
  assign w_vertex_quiet = rs_empty & vertex_done;
  assign w_in_drain     = (r_state == S_EDGE_DRAIN) || (r_state == S_VERTEX_DRAIN);
  assign w_quiet        = (r_state == S_EDGE_DRAIN) ? w_edge_quiet : w_vertex_quiet;
  assign w_settled      = w_quiet && (r_settle == SETTLE_LAST);
  assign w_start_ok     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_iter    = (r_cur_iter == r_num_iter);
  assign w_state_change = (w_state_next != r_state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    dispatch_en     = 1'b0;
    vertex_en       = 1'b0;
    task_complete   = 1'b0;
    busy            = 1'b1;
    phase           = r_state;
    cur_replay_iter = r_cur_iter;
    iter_advance    = r_iter_advance;
    timeout_err     = r_timeout_err;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_DISPATCH;
      end
      S_DISPATCH: begin
        dispatch_en = 1'b1;
        if (dispatch_empty) w_state_next = S_EDGE_DRAIN;
      end
      S_EDGE_DRAIN: begin
        if (w_settled) w_state_next = S_VERTEX;
      end
      S_VERTEX: begin
        vertex_en    = 1'b1;
        w_state_next = S_VERTEX_DRAIN;
      end
      S_VERTEX_DRAIN: begin
        if (w_settled) w_state_next = S_NEXT_ITER;
      end
      S_NEXT_ITER: begin
        w_state_next = w_last_iter ? S_DONE : S_DISPATCH;
      end
      S_DONE: begin
        busy          = 1'b0;
        task_complete = 1'b1;
        if (start) w_state_next = S_DISPATCH;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Settle and timeout counters both restart whenever the state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_settle       <= '0;
      r_tmo          <= '0;
      r_num_iter     <= '0;
      r_cur_iter     <= '0;
      r_iter_advance <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_iter_advance <= 1'b0;
      if (w_state_change) begin
        r_settle <= '0;
      end else if (w_in_drain) begin
        r_settle <= w_quiet ? (r_settle + SETTLE_ONE) : '0;
      end
      if (w_state_change) begin
        r_tmo <= '0;
      end else if (w_in_drain && (r_tmo != TMO_MAX)) begin
        r_tmo <= r_tmo + TMO_ONE;
        if (r_tmo == TMO_HIT) r_timeout_err <= 1'b1;
      end
      if (w_start_ok) begin
        r_num_iter    <= num_iter;
        r_cur_iter    <= '0;
        r_timeout_err <= 1'b0;
      end
      // The last-iteration check comes first, so the index never wraps.
      if ((r_state == S_NEXT_ITER) && !w_last_iter) begin
        r_cur_iter     <= r_cur_iter + ITER_ONE;
        r_iter_advance <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_replay_phase_sequencer.sv
// Scoreboard bench for replay_phase_sequencer: stimulus queues expected phase events,
// a monitor pops and compares them as vertex_en, iter_advance and task_complete fire.
module tb_replay_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] num_iter;
  logic       dispatch_empty;
  logic [3:0] pe_idle;
  logic       edge_buffer_busy;
  logic       rs_empty;
  logic       vertex_done;
  logic       dispatch_en;
  logic       vertex_en;
  logic [1:0] cur_replay_iter;
  logic       iter_advance;
  logic       task_complete;
  logic       busy;
  logic       timeout_err;
  logic [2:0] phase;

  replay_phase_sequencer #(
    .NUM_EDGE_PE(4),
    .ITER_W(2),
    .SETTLE_CYC(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_iter(num_iter),
    .dispatch_empty(dispatch_empty),
    .pe_idle(pe_idle),
    .edge_buffer_busy(edge_buffer_busy),
    .rs_empty(rs_empty),
    .vertex_done(vertex_done),
    .dispatch_en(dispatch_en),
    .vertex_en(vertex_en),
    .cur_replay_iter(cur_replay_iter),
    .iter_advance(iter_advance),
    .task_complete(task_complete),
    .busy(busy),
    .timeout_err(timeout_err),
    .phase(phase)
  );

  always #5 clk = ~clk;

  // kind: 0 = vertex_en pulse (a = dispatch_en cycles, b = EDGE_DRAIN cycles),
  //       1 = iter_advance pulse, 2 = task_complete rise (a = cycles since vertex_en).
  typedef struct {
    int kind;
    int iter;
    int a;
    int b;
    int tmo;
  } ev_t;

  ev_t exp_q[$];
  int  cmp_cnt = 0;
  int  err_cnt = 0;

  logic [11:0] outs_packed;
  assign outs_packed = {dispatch_en, vertex_en, cur_replay_iter, iter_advance,
                        task_complete, busy, timeout_err, phase};

  function automatic void push_ev(int k, int it, int a, int b, int t);
    ev_t e;
    e.kind = k; e.iter = it; e.a = a; e.b = b; e.tmo = t;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(string name, int act, int req);
    cmp_cnt++;
    if (act != req) begin
      err_cnt++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endfunction

  function automatic void mon_cmp(int k, int it, int a, int b, int t);
    ev_t e;
    cmp_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL unexpected_event: got kind=%0d iter=%0d a=%0d b=%0d tmo=%0d, required no event",
               k, it, a, b, t);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.iter != it || e.a != a || e.b != b || e.tmo != t) begin
        err_cnt++;
        $display("FAIL event: got kind=%0d iter=%0d a=%0d b=%0d tmo=%0d, required kind=%0d iter=%0d a=%0d b=%0d tmo=%0d",
                 k, it, a, b, t, e.kind, e.iter, e.a, e.b, e.tmo);
      end else begin
        $display("ev   kind=%0d iter=%0d a=%0d b=%0d tmo=%0d", k, it, a, b, t);
      end
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int dcnt;
    int ecnt;
    int sv;
    logic prev_tc;
    dcnt = 0; ecnt = 0; sv = 0; prev_tc = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dcnt = 0; ecnt = 0; sv = 0; prev_tc = 1'b0;
      end else begin
        if (dispatch_en) dcnt++;
        if (phase == 3'd2) ecnt++;
        sv++;
        if (vertex_en) begin
          mon_cmp(0, int'(cur_replay_iter), dcnt, ecnt, int'(timeout_err));
          dcnt = 0; ecnt = 0; sv = 0;
        end
        if (iter_advance) mon_cmp(1, int'(cur_replay_iter), 0, 0, int'(timeout_err));
        if (task_complete && !prev_tc) mon_cmp(2, int'(cur_replay_iter), sv, 0, int'(timeout_err));
        prev_tc = task_complete;
      end
    end
  end

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (int'(phase) != p && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (int'(phase) != p) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL wait_phase: got phase %0d after %0d cycles, required %0d", phase, n, p);
    end
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    num_iter = 2'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds dispatch_empty low so dispatch_en lasts 'hold' cycles; optionally pokes start mid-dispatch.
  task automatic dispatch(input int hold, input bit poke);
    wait_phase(1);
    if (poke) begin
      start    = 1'b1;
      num_iter = 2'd0;
    end
    repeat (hold - 1) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (poke) chk("ignored_start_iter", int'(cur_replay_iter), 1);
    dispatch_empty = 1'b1;
    @(negedge clk);
    dispatch_empty = 1'b0;
  endtask

  initial begin
    logic [11:0] any;
    reset = 1'b0; start = 1'b0; num_iter = 2'd0; dispatch_empty = 1'b0;
    pe_idle = 4'hF; edge_buffer_busy = 1'b0; rs_empty = 1'b1; vertex_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs_packed), 0);
    reset = 1'b1;
    any = '0;
    repeat (10) begin
      @(negedge clk);
      any |= outs_packed;
    end
    chk("idle_after_reset", int'(any), 0);

    // Single iteration
    push_ev(0, 0, 3, 4, 0);
    push_ev(2, 0, 6, 0, 0);
    do_start(0);
    dispatch(3, 1'b0);
    wait_phase(6);
    chk("single_iter", int'(cur_replay_iter), 0);
    chk("single_tc", int'(task_complete), 1);
    chk("single_busy", int'(busy), 0);

    // Three iterations, restarted from DONE, with an ignored start in iteration 1
    push_ev(0, 0, 2, 4, 0);
    push_ev(1, 1, 0, 0, 0);
    push_ev(0, 1, 2, 4, 0);
    push_ev(1, 2, 0, 0, 0);
    push_ev(0, 2, 2, 4, 0);
    push_ev(2, 2, 6, 0, 0);
    do_start(2);
    dispatch(2, 1'b0);
    dispatch(2, 1'b1);
    dispatch(2, 1'b0);
    wait_phase(6);
    chk("three_iter_final", int'(cur_replay_iter), 2);

    // Quiet glitch on the 3rd drain cycle restarts settling
    push_ev(0, 0, 1, 7, 0);
    push_ev(2, 0, 6, 0, 0);
    do_start(0);
    dispatch(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    pe_idle = 4'hB;
    @(negedge clk);
    pe_idle = 4'hF;
    wait_phase(6);

    // Drain timeout: flag at 64 cycles, run continues, flag sticky until next start
    push_ev(0, 0, 1, 74, 1);
    push_ev(1, 1, 0, 0, 1);
    push_ev(0, 1, 1, 4, 1);
    push_ev(2, 1, 6, 0, 1);
    pe_idle = 4'h7;
    do_start(1);
    dispatch(1, 1'b0);
    repeat (63) @(negedge clk);
    chk("timeout_before", int'(timeout_err), 0);
    @(negedge clk);
    chk("timeout_set", int'(timeout_err), 1);
    chk("timeout_phase", int'(phase), 2);
    repeat (6) @(negedge clk);
    pe_idle = 4'hF;
    dispatch(1, 1'b0);
    wait_phase(6);
    chk("timeout_sticky", int'(timeout_err), 1);

    // Maximum num_iter: no wrap, flag cleared by start
    push_ev(0, 0, 1, 4, 0);
    push_ev(1, 1, 0, 0, 0);
    push_ev(0, 1, 1, 4, 0);
    push_ev(1, 2, 0, 0, 0);
    push_ev(0, 2, 1, 4, 0);
    push_ev(1, 3, 0, 0, 0);
    push_ev(0, 3, 1, 4, 0);
    push_ev(2, 3, 6, 0, 0);
    do_start(3);
    repeat (4) dispatch(1, 1'b0);
    wait_phase(6);
    chk("max_iter_final", int'(cur_replay_iter), 3);

    // Async reset during VERTEX_DRAIN of iteration 1
    push_ev(0, 0, 1, 4, 0);
    push_ev(1, 1, 0, 0, 0);
    push_ev(0, 1, 1, 4, 0);
    do_start(2);
    dispatch(1, 1'b0);
    dispatch(1, 1'b0);
    wait_phase(4);
    chk("pre_reset_iter", int'(cur_replay_iter), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_phase", int'(phase), 0);
    chk("async_reset_iter", int'(cur_replay_iter), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    any = '0;
    repeat (10) begin
      @(negedge clk);
      any |= outs_packed;
    end
    chk("idle_after_midrun_reset", int'(any), 0);

    repeat (3) @(negedge clk);
    chk("events_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/replay_phase_sequencer.md
Name: replay_phase_sequencer

Overview:
- Top-level run controller that sequences one task through all replay iterations.
- Per iteration: enables Edge PE dispatch, waits for the edge path to drain, fires the vertex phase, waits for the vertex path to drain, then advances the iteration.
- Sits between the packet decoder, the Edge PE array, edge_buffer/Vertex_RS/vertex_buffer and the FV/neighbor controllers.
- Drives the shared current replay iteration and task_complete.

Parameters:
- NUM_EDGE_PE, 4, number of Edge PEs whose idle flags are monitored.
- ITER_W, 2, width of the replay iteration index (clog2 of Max_replay_Iter).
- SETTLE_CYC, 4, consecutive quiet cycles required before a drain is declared complete (must be ≥1).
- TIMEOUT, 1024, drain-state cycle limit before timeout_err is raised.

Ports:
- clk  input  1  global clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request pulse, sampled in IDLE or DONE only.
- num_iter  input  ITER_W  index of the last replay iteration, latched on accepted start.
- dispatch_empty  input  1  packet decoder has issued all tasks for the current iteration.
- pe_idle  input  NUM_EDGE_PE  per-PE idle flags.
- edge_buffer_busy  input  1  edge accumulation buffer holds or is moving data.
- rs_empty  input  1  Vertex_RS has no entries.
- vertex_done  input  1  vertex_buffer empty and all write-backs granted.
- dispatch_en  output  1  permits the decoder to issue tasks.
- vertex_en  output  1  one-cycle pulse starting the vertex phase.
- cur_replay_iter  output  ITER_W  current replay iteration.
- iter_advance  output  1  one-cycle pulse when cur_replay_iter increments.
- task_complete  output  1  run finished; held high.
- busy  output  1  high in every state except IDLE and DONE.
- timeout_err  output  1  sticky drain-timeout flag.
- phase  output  3  state encoding, for debug.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, including cur_replay_iter. Counters and latched num_iter cleared.
- All outputs decode from registers; there are no combinational input-to-output paths.

State encoding: IDLE=0, DISPATCH=1, EDGE_DRAIN=2, VERTEX=3, VERTEX_DRAIN=4, NEXT_ITER=5, DONE=6. Value 7 is unreachable and recovers to IDLE.

Transitions:
- IDLE: on start, latch num_iter, set cur_replay_iter=0, go to DISPATCH.
- DISPATCH: dispatch_en=1. On dispatch_empty, go to EDGE_DRAIN; dispatch_en drops in the same cycle the state changes.
- EDGE_DRAIN:
  - quiet = (&pe_idle) & ~edge_buffer_busy.
  - settle counter increments on quiet and clears on any non-quiet cycle.
  - On the SETTLE_CYC-th consecutive quiet cycle, go to VERTEX.
- VERTEX: vertex_en=1 for exactly one cycle, then go to VERTEX_DRAIN.
- VERTEX_DRAIN:
  - quiet = rs_empty & vertex_done.
  - Same settle rule as EDGE_DRAIN; then go to NEXT_ITER.
- NEXT_ITER:
  - If cur_replay_iter == latched num_iter: go to DONE.
  - Else: increment cur_replay_iter, pulse iter_advance, go to DISPATCH.
- DONE: task_complete=1 and cur_replay_iter held. On start, behave as IDLE+start (clear task_complete, relatch, iter=0, go to DISPATCH).

Rules and boundary conditions:
- Settle counter clears on every state entry.
- Timeout counter:
  - Counts cycles spent in EDGE_DRAIN or VERTEX_DRAIN and clears on entry to either state.
  - When it reaches TIMEOUT, set timeout_err. The counter saturates and the state does not change; the sequencer keeps waiting.
  - timeout_err clears only on reset or an accepted start.
- start is ignored in all states except IDLE and DONE.
- num_iter changes after latch are ignored.
- dispatch_empty already high on DISPATCH entry: dispatch_en is high for exactly 1 cycle.
- num_iter=0: one iteration, no iter_advance pulse.
- num_iter = 2^ITER_W-1: cur_replay_iter never wraps, because the DONE check precedes the increment.
- Reset asserted mid-run: immediate return to IDLE; any pending vertex_en or iter_advance pulse is suppressed.

Test Plan:
- Reset check: hold reset=0, then release → all outputs 0, phase=0, and no pulses during the first 10 cycles.
- Single iteration:
  - Setup: num_iter=0, start, dispatch_empty after 3 cycles, pe_idle=4'hF, edge_buffer_busy=0, SETTLE_CYC=4.
  - Required: dispatch_en high 3 cycles; vertex_en pulses 4 cycles after EDGE_DRAIN entry.
  - Then rs_empty=vertex_done=1 → task_complete=1 exactly 6 cycles after the vertex_en pulse (4 settle + NEXT_ITER + DONE); cur_replay_iter=0; iter_advance never pulses.
- Three iterations, num_iter=2 → iter_advance pulses twice, cur_replay_iter steps 0→1→2, three vertex_en pulses, task_complete set after the third drain.
- Quiet glitch: pe_idle[2] drops for 1 cycle on the 3rd quiet cycle of EDGE_DRAIN → settle restarts; VERTEX is entered only after 4 further consecutive quiet cycles.
- Timeout:
  - TIMEOUT=64, pe_idle=4'h7 held → timeout_err=1 after 64 cycles in EDGE_DRAIN, phase stays 2.
  - Later pe_idle=4'hF → run proceeds, and timeout_err stays 1 until the next start.
- Ignored start and async reset:
  - start pulse during DISPATCH → no relatch, cur_replay_iter unchanged.
  - reset asserted in VERTEX_DRAIN of iteration 1 → same cycle phase=0, cur_replay_iter=0, busy=0.
